// File: rtl/fft_frame_sequencer_if.sv
// Streaming bus between the sample source, the frame sequencer and the FFT core.
// The master side is the sequencer; the slave side is the source/core environment.
interface fft_frame_sequencer_if #(
  parameter int DW = 8
);
  logic          up_valid;
  logic          up_ready;
  logic [DW-1:0] up_real;
  logic [DW-1:0] up_imag;

  logic          fft_sink_valid;
  logic          fft_sink_sop;
  logic          fft_sink_eop;
  logic [DW-1:0] fft_sink_real;
  logic [DW-1:0] fft_sink_imag;
  logic          fft_inverse;
  logic          fft_sink_ready;

  logic          fft_source_valid;
  logic          fft_source_sop;
  logic          fft_source_eop;
  logic [1:0]    fft_source_error;

  modport master (
    input  up_valid, up_real, up_imag, fft_sink_ready,
    input  fft_source_valid, fft_source_sop, fft_source_eop, fft_source_error,
    output up_ready, fft_sink_valid, fft_sink_sop, fft_sink_eop,
    output fft_sink_real, fft_sink_imag, fft_inverse
  );

  modport slave (
    output up_valid, up_real, up_imag, fft_sink_ready,
    output fft_source_valid, fft_source_sop, fft_source_eop, fft_source_error,
    input  up_ready, fft_sink_valid, fft_sink_sop, fft_sink_eop,
    input  fft_sink_real, fft_sink_imag, fft_inverse
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Cuts an upstream sample stream into FFT_LEN-point frames for the FFT core, limits the
// number of frames the core holds and checks the framing of what the core sends back.
module fft_frame_sequencer #(
  parameter int FFT_LEN = 1024,
  parameter int CNT_W   = 10,
  parameter int DW      = 8,
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             inverse_req,
  fft_frame_sequencer_if.master bus,
  output logic [CNT_W-1:0] in_cnt,
  output logic [CNT_W-1:0] out_cnt,
  output logic [1:0]       in_flight,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERROR} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FFT_LEN - 1);
  localparam logic [1:0]       OUT_LIMIT = 2'(MAX_OUT);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] in_cnt_reg, in_cnt_next;
  logic [CNT_W-1:0] out_cnt_reg, out_cnt_next;
  logic [1:0]       in_flight_reg, in_flight_next;
  logic             stop_pend_reg, stop_pend_next;
  logic             inverse_reg, inverse_next;

  logic at_boundary, gate, acc, fl_inc, fl_dec, src_eop, src_fault;

  // New frames are only held back at a frame boundary, so frames are never truncated.
  assign at_boundary = (in_cnt_reg == '0);
  assign gate = (state_reg == RUN)
              && !(at_boundary && (in_flight_reg == OUT_LIMIT))
              && !(at_boundary && stop_pend_reg);

  assign bus.up_ready       = gate & bus.fft_sink_ready;
  assign bus.fft_sink_valid = gate & bus.up_valid;
  assign bus.fft_sink_sop   = bus.fft_sink_valid & at_boundary;
  assign bus.fft_sink_eop   = bus.fft_sink_valid & (in_cnt_reg == LAST_BEAT);
  assign bus.fft_sink_real  = bus.up_real;
  assign bus.fft_sink_imag  = bus.up_imag;
  assign bus.fft_inverse    = inverse_reg;

  assign acc     = bus.up_valid & bus.up_ready;
  assign src_eop = bus.fft_source_valid & bus.fft_source_eop;
  assign fl_inc  = acc & bus.fft_sink_eop;
  assign fl_dec  = src_eop & (in_flight_reg != 2'd0);

  // Output beats must line up with out_cnt; an eop with nothing outstanding is an underflow.
  assign src_fault = (bus.fft_source_valid
                      & ((bus.fft_source_error != 2'b00)
                         | (bus.fft_source_sop != (out_cnt_reg == '0))
                         | (bus.fft_source_eop != (out_cnt_reg == LAST_BEAT))))
                   | (src_eop & (in_flight_reg == 2'd0));

  always_comb begin
    state_next     = state_reg;
    stop_pend_next = stop_pend_reg;
    in_cnt_next    = in_cnt_reg;
    out_cnt_next   = out_cnt_reg;
    in_flight_next = in_flight_reg;
    inverse_next   = inverse_reg;

    if (acc) begin
      in_cnt_next = (in_cnt_reg == LAST_BEAT) ? '0 : in_cnt_reg + 1'b1;
    end
    if (bus.fft_source_valid) begin
      out_cnt_next = (out_cnt_reg == LAST_BEAT) ? '0 : out_cnt_reg + 1'b1;
    end
    if (acc && at_boundary) begin
      inverse_next = inverse_req;
    end
    case ({fl_inc, fl_dec})
      2'b10:   in_flight_next = in_flight_reg + 2'd1;
      2'b01:   in_flight_next = in_flight_reg - 2'd1;
      default: in_flight_next = in_flight_reg;
    endcase

    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (stop) stop_pend_next = 1'b1;
        if (src_fault) begin
          state_next = ERROR;
        end else if ((stop || stop_pend_reg) && at_boundary && !acc) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (src_fault) begin
          state_next = ERROR;
        end else if ((in_flight_reg == 2'd0) && (out_cnt_reg == '0)) begin
          state_next     = IDLE;
          stop_pend_next = 1'b0;
        end
      end
      ERROR: begin
        if (clear) begin
          state_next     = IDLE;
          in_cnt_next    = '0;
          out_cnt_next   = '0;
          in_flight_next = 2'd0;
          stop_pend_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      in_cnt_reg    <= '0;
      out_cnt_reg   <= '0;
      in_flight_reg <= 2'd0;
      stop_pend_reg <= 1'b0;
      inverse_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_cnt_reg    <= in_cnt_next;
      out_cnt_reg   <= out_cnt_next;
      in_flight_reg <= in_flight_next;
      stop_pend_reg <= stop_pend_next;
      inverse_reg   <= inverse_next;
    end
  end

  assign in_cnt    = in_cnt_reg;
  assign out_cnt   = out_cnt_reg;
  assign in_flight = in_flight_reg;
  assign busy      = (state_reg != IDLE);
  assign err       = (state_reg == ERROR);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: framing, backpressure, inverse latching,
// stop/drain and source-side error handling with a 1024-point frame.
module tb_fft_frame_sequencer;
  localparam int LEN   = 1024;
  localparam int CNT_W = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, inverse_req = 1'b0;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic [1:0] in_flight;
  logic busy, err;

  fft_frame_sequencer_if #(.DW(8)) bus ();

  fft_frame_sequencer #(.FFT_LEN(LEN), .CNT_W(CNT_W), .DW(8), .MAX_OUT(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
    .inverse_req(inverse_req), .bus(bus), .in_cnt(in_cnt), .out_cnt(out_cnt),
    .in_flight(in_flight), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int up_beats = 0;
  int src_frames = 0;
  int src_beat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: counts an accepted upstream beat and plays queued core output frames.
  task automatic step();
    logic acc;
    #1;
    acc = bus.up_valid & bus.up_ready;
    @(posedge clk);
    #1;
    if (acc) up_beats++;
    if (src_frames > 0 && bus.fft_source_valid) begin
      if (src_beat == LEN - 1) begin
        src_beat = 0;
        src_frames--;
      end else begin
        src_beat++;
      end
    end
    bus.fft_source_valid = (src_frames > 0);
    bus.fft_source_sop   = (src_frames > 0) && (src_beat == 0);
    bus.fft_source_eop   = (src_frames > 0) && (src_beat == LEN - 1);
    #1;
  endtask

  initial begin
    int idx;
    int early_ready, trk_bad, inv_bad, busy_bad;
    logic stop_sent;
    bus.up_valid = 1'b0; bus.up_real = '0; bus.up_imag = '0; bus.fft_sink_ready = 1'b0;
    bus.fft_source_valid = 1'b0; bus.fft_source_sop = 1'b0; bus.fft_source_eop = 1'b0;
    bus.fft_source_error = 2'b00;

    // Reset values
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_in_cnt", 32'(in_cnt), 0);
    chk("rst_out_cnt", 32'(out_cnt), 0);
    chk("rst_in_flight", 32'(in_flight), 0);
    chk("rst_inverse", 32'(bus.fft_inverse), 0);
    chk("rst_up_ready", 32'(bus.up_ready), 0);
    #20 reset_n = 1'b1;

    // T1: two back-to-back frames at full rate
    bus.fft_sink_ready = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    bus.up_valid = 1'b1;
    bus.up_real = 8'hA5;
    bus.up_imag = 8'h3C;
    #1;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_real_pass", 32'(bus.fft_sink_real), 32'h A5);
    chk("t1_imag_pass", 32'(bus.fft_sink_imag), 32'h3C);
    for (int c = 0; c < 2200 && up_beats < 2048; c++) begin
      if (bus.up_valid && bus.up_ready) begin
        idx = up_beats;
        if (idx == 0 || idx == 1 || idx == 1023 || idx == 1024 || idx == 2047) begin
          chk("t1_sop", 32'(bus.fft_sink_sop), 32'(idx % LEN == 0));
          chk("t1_eop", 32'(bus.fft_sink_eop), 32'(idx % LEN == LEN - 1));
          chk("t1_in_cnt", 32'(in_cnt), 32'(idx % LEN));
        end
      end
      step();
    end
    chk("t1_beats", 32'(up_beats), 2048);
    chk("t1_in_flight", 32'(in_flight), 2);
    chk("t1_in_cnt_wrap", 32'(in_cnt), 0);

    // T2: in-flight limit holds the third frame until one core eop
    for (int c = 0; c < 5; c++) step();
    chk("t2_up_ready_low", 32'(bus.up_ready), 0);
    chk("t2_sink_valid_low", 32'(bus.fft_sink_valid), 0);
    early_ready = 0;
    src_frames = 1;
    for (int c = 0; c < 1200 && src_frames > 0; c++) begin
      step();
      if (src_frames > 0 && bus.up_ready !== 1'b0) early_ready++;
    end
    chk("t2_src_done", 32'(src_frames), 0);
    chk("t2_ready_held", 32'(early_ready), 0);
    chk("t2_in_flight", 32'(in_flight), 1);
    chk("t2_out_cnt", 32'(out_cnt), 0);
    chk("t2_up_ready_back", 32'(bus.up_ready), 1);
    chk("t2_sop", 32'(bus.fft_sink_sop), 1);

    // T3/T4: sink_ready toggling, inverse_req flips at beat 500 of frame 3
    trk_bad = 0;
    inv_bad = 0;
    src_frames = 1;
    for (int c = 0; c < 3000 && up_beats < 3073; c++) begin
      if (in_cnt != CNT_W'(up_beats % LEN)) trk_bad++;
      if (up_beats <= 3072 && bus.fft_inverse !== 1'b0) inv_bad++;
      if (bus.up_valid && bus.up_ready) begin
        idx = up_beats;
        if (idx == 2048 + 500) inverse_req = 1'b1;
        if (idx == 3071) begin
          chk("t3_eop_1024th", 32'(bus.fft_sink_eop), 1);
          chk("t3_no_sop_at_eop", 32'(bus.fft_sink_sop), 0);
          chk("t4_inverse_held", 32'(bus.fft_inverse), 0);
        end
      end
      bus.fft_sink_ready = ~bus.fft_sink_ready;
      step();
    end
    chk("t3_beats", 32'(up_beats), 3073);
    chk("t3_in_cnt_track", 32'(trk_bad), 0);
    chk("t4_inverse_stable", 32'(inv_bad), 0);
    chk("t4_inverse_follows", 32'(bus.fft_inverse), 1);
    chk("t3_in_cnt", 32'(in_cnt), 1);

    // T5: stop at beat 300 of frame 4, then drain
    bus.fft_sink_ready = 1'b1;
    stop_sent = 1'b0;
    for (int c = 0; c < 1200 && up_beats < 4096; c++) begin
      if (up_beats == 3072 + 300 && !stop_sent) begin
        stop = 1'b1;
        stop_sent = 1'b1;
      end else begin
        stop = 1'b0;
      end
      step();
    end
    stop = 1'b0;
    chk("t5_beats", 32'(up_beats), 4096);
    chk("t5_in_cnt", 32'(in_cnt), 0);
    chk("t5_gate_closed", 32'(bus.up_ready), 0);
    chk("t5_in_flight", 32'(in_flight), 2);
    step();
    chk("t5_drain_busy", 32'(busy), 1);
    chk("t5_drain_no_valid", 32'(bus.fft_sink_valid), 0);
    busy_bad = 0;
    src_frames = 2;
    for (int c = 0; c < 2200 && src_frames > 0; c++) begin
      step();
      if (busy !== 1'b1) busy_bad++;
    end
    chk("t5_src_done", 32'(src_frames), 0);
    chk("t5_busy_in_drain", 32'(busy_bad), 0);
    chk("t5_in_flight_zero", 32'(in_flight), 0);
    chk("t5_out_cnt_zero", 32'(out_cnt), 0);
    step();
    chk("t5_idle", 32'(busy), 0);
    chk("t5_no_extra_beats", 32'(up_beats), 4096);
    chk("t5_no_err", 32'(err), 0);

    // T6: misplaced source sop raises err; clear returns to IDLE with counters cleared
    bus.up_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    chk("t6_run", 32'(busy), 1);
    chk("t6_up_ready", 32'(bus.up_ready), 1);
    for (int i = 0; i < 5; i++) begin
      bus.fft_source_valid = 1'b1;
      bus.fft_source_sop = (i == 0);
      bus.fft_source_eop = 1'b0;
      step();
    end
    chk("t6_out_cnt5", 32'(out_cnt), 5);
    chk("t6_no_err_yet", 32'(err), 0);
    bus.fft_source_valid = 1'b1;
    bus.fft_source_sop = 1'b1;
    step();
    chk("t6_err_sop", 32'(err), 1);
    chk("t6_err_ready", 32'(bus.up_ready), 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t6_clear_err", 32'(err), 0);
    chk("t6_clear_busy", 32'(busy), 0);
    chk("t6_clear_out_cnt", 32'(out_cnt), 0);
    chk("t6_clear_in_flight", 32'(in_flight), 0);

    // start and stop together in IDLE: start wins, stop is dropped
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    step();
    step();
    chk("t6_start_wins", 32'(busy), 1);
    chk("t6_stop_dropped", 32'(bus.up_ready), 1);

    // source error code
    bus.fft_source_valid = 1'b1;
    bus.fft_source_sop = 1'b1;
    bus.fft_source_error = 2'b01;
    step();
    bus.fft_source_error = 2'b00;
    chk("t6_err_code", 32'(err), 1);

    // asynchronous reset while in ERROR
    reset_n = 1'b0;
    #1;
    chk("t6_async_rst_err", 32'(err), 0);
    chk("t6_async_rst_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
